// File: rtl/iob_fp_pack_pkg.sv
// Shared definitions for the FP packer and neighbouring FP units.
//   fp_state_t : packer FSM state encoding
//   fp_man_w   : mantissa width (hidden bit + fraction) from word/exponent widths
//   fp_bias    : exponent bias for a given exponent width
// The canonical quiet-NaN and infinity encodings are built from these
// widths inside each unit, so they follow the instance parameters.
package iob_fp_pack_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_NORM  = 2'd1,
        ST_ROUND = 2'd2,
        ST_DONE  = 2'd3
    } fp_state_t;

    function automatic int fp_man_w(input int data_w, input int exp_w);
        return data_w - exp_w;
    endfunction

    function automatic int fp_bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

endpackage

// File: rtl/iob_fp_round.sv
// Combinational round-to-nearest-even stage.
//   mant     : [MAN_W+2] hidden, [MAN_W+1:3] fraction, [2] G, [1] R, [0] S
//   exp_val  : signed biased exponent of the hidden position
//   mant_rnd : rounded hidden+fraction (MAN_W bits)
//   exp_rnd  : exponent after a possible carry, one bit wider so it cannot wrap
//   inexact  : any of G/R/S set
//   carry    : rounding carried out of the hidden bit
module iob_fp_round #(
    parameter int MAN_W = 24,
    parameter int EXP_W = 8
) (
    input  logic [MAN_W+2:0]        mant,
    input  logic signed [EXP_W+1:0] exp_val,
    output logic [MAN_W-1:0]        mant_rnd,
    output logic signed [EXP_W+2:0] exp_rnd,
    output logic                    inexact,
    output logic                    carry
);
    logic             lsb, g, r, s, inc;
    logic [MAN_W:0]   sum;
    logic [EXP_W+2:0] exp_ext;

    assign lsb = mant[3];
    assign g   = mant[2];
    assign r   = mant[1];
    assign s   = mant[0];

    // Ties (G set, R/S clear) only round up when the kept LSB is odd.
    assign inc     = g & (r | s | lsb);
    assign sum     = {1'b0, mant[MAN_W+2:3]} + {{MAN_W{1'b0}}, inc};
    assign carry   = sum[MAN_W];
    assign inexact = g | r | s;

    // A carry means the significand was all ones: result is exactly 1.0 * 2^(e+1).
    assign mant_rnd = carry ? {1'b1, {(MAN_W-1){1'b0}}} : sum[MAN_W-1:0];
    assign exp_ext  = {exp_val[EXP_W+1], exp_val};
    assign exp_rnd  = exp_ext + {{(EXP_W+2){1'b0}}, carry};

endmodule

// File: rtl/iob_fp_pack.sv
// Sequential IEEE-754 packer: normalizes one bit per cycle, rounds to
// nearest-even and encodes NaN / infinity / zero / subnormal results.
//   clk_i, cke_i, arst_i : clock, clock enable, async active-high reset
//   start_i              : request, taken only while busy_o is low
//   sign_i, exp_i, mant_i: sign, signed biased exponent, mantissa with G/R/S
//   nan_i, inf_i         : force quiet NaN / infinity
//   busy_o               : operation in NORM or ROUND
//   done_o               : one-cycle pulse, data_o and flags valid
//   data_o, overflow_o, underflow_o, inexact_o : result, held until next start
module iob_fp_pack
    import iob_fp_pack_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int EXP_W  = 8
) (
    input  logic                    clk_i,
    input  logic                    cke_i,
    input  logic                    arst_i,
    input  logic                    start_i,
    input  logic                    sign_i,
    input  logic [EXP_W+1:0]        exp_i,
    input  logic [DATA_W-EXP_W+2:0] mant_i,
    input  logic                    nan_i,
    input  logic                    inf_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic [DATA_W-1:0]       data_o,
    output logic                    overflow_o,
    output logic                    underflow_o,
    output logic                    inexact_o
);
    localparam int MAN_W = fp_man_w(DATA_W, EXP_W);
    localparam int MW    = MAN_W + 3;

    localparam logic signed [EXP_W+1:0] EXP_ONE      = (EXP_W+2)'(1);
    localparam logic signed [EXP_W+1:0] EXP_COLLAPSE = (EXP_W+2)'(-(MAN_W + 2));
    localparam logic signed [EXP_W+2:0] EXP_OVF      = (EXP_W+3)'((1 << EXP_W) - 1);

    fp_state_t               state, state_nxt;
    logic                    sign_q;
    logic signed [EXP_W+1:0] exp_q, exp_nxt;
    logic [MW-1:0]           mant_q, mant_nxt;

    logic                    accept, special;
    logic [DATA_W-1:0]       special_word;
    logic                    do_collapse, do_right, do_left, norm_busy;

    logic [MAN_W-1:0]        rnd_mant;
    logic signed [EXP_W+2:0] rnd_exp;
    logic                    rnd_inexact, rnd_carry, hidden, ovf;
    logic [DATA_W-1:0]       pack_word;
    logic                    pack_ovf, pack_unf, pack_inx;

    // busy_o is low in IDLE and DONE, so a start coincident with done_o is taken.
    assign accept = start_i & ~busy_o;

    always_comb begin
        special = nan_i | inf_i | (mant_i == '0);
        if (nan_i)
            special_word = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-2){1'b0}}};
        else if (inf_i)
            special_word = {sign_i, {EXP_W{1'b1}}, {(MAN_W-1){1'b0}}};
        else
            special_word = {sign_i, {(DATA_W-1){1'b0}}};
    end

    // One normalization action per cycle. The collapse case can only hold on
    // the first NORM cycle: every other action moves the exponent toward 1.
    always_comb begin
        do_collapse = exp_q < EXP_COLLAPSE;
        do_right    = exp_q < EXP_ONE;
        do_left     = ~mant_q[MW-1] & (exp_q > EXP_ONE);
        norm_busy   = do_collapse | do_right | do_left;
        mant_nxt    = mant_q;
        exp_nxt     = exp_q;
        if (do_collapse) begin
            mant_nxt = {{(MW-1){1'b0}}, |mant_q};
            exp_nxt  = EXP_ONE;
        end else if (do_right) begin
            mant_nxt = {1'b0, mant_q[MW-1:2], mant_q[1] | mant_q[0]};
            exp_nxt  = exp_q + EXP_ONE;
        end else if (do_left) begin
            mant_nxt = {mant_q[MW-2:0], 1'b0};
            exp_nxt  = exp_q - EXP_ONE;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (accept) state_nxt = special ? ST_DONE : ST_NORM;
                else        state_nxt = ST_IDLE;
            end
            ST_NORM:  if (!norm_busy) state_nxt = ST_ROUND;
            ST_ROUND: state_nxt = ST_DONE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    iob_fp_round #(
        .MAN_W (MAN_W),
        .EXP_W (EXP_W)
    ) u_round (
        .mant     (mant_q),
        .exp_val  (exp_q),
        .mant_rnd (rnd_mant),
        .exp_rnd  (rnd_exp),
        .inexact  (rnd_inexact),
        .carry    (rnd_carry)
    );

    // Hidden bit clear after rounding means subnormal (or zero): exponent
    // field 0. A subnormal that rounds into the hidden bit becomes the
    // minimum normal with exponent 1, which exp_q already holds.
    always_comb begin
        hidden   = rnd_carry | rnd_mant[MAN_W-1];
        ovf      = rnd_exp >= EXP_OVF;
        pack_ovf = 1'b0;
        pack_unf = 1'b0;
        pack_inx = rnd_inexact;
        if (ovf) begin
            pack_word = {sign_q, {EXP_W{1'b1}}, {(MAN_W-1){1'b0}}};
            pack_ovf  = 1'b1;
            pack_inx  = 1'b1;
        end else begin
            pack_word = {sign_q, hidden ? rnd_exp[EXP_W-1:0] : {EXP_W{1'b0}},
                         rnd_mant[MAN_W-2:0]};
            pack_unf  = ~hidden & rnd_inexact;
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state       <= ST_IDLE;
            sign_q      <= 1'b0;
            exp_q       <= '0;
            mant_q      <= '0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            data_o      <= '0;
            overflow_o  <= 1'b0;
            underflow_o <= 1'b0;
            inexact_o   <= 1'b0;
        end else if (cke_i) begin
            state  <= state_nxt;
            busy_o <= (state_nxt == ST_NORM) || (state_nxt == ST_ROUND);
            done_o <= (state_nxt == ST_DONE);
            if (accept) begin
                sign_q      <= sign_i;
                exp_q       <= exp_i;
                mant_q      <= mant_i;
                overflow_o  <= 1'b0;
                underflow_o <= 1'b0;
                inexact_o   <= 1'b0;
                if (special) data_o <= special_word;
            end else if (state == ST_NORM) begin
                mant_q <= mant_nxt;
                exp_q  <= exp_nxt;
            end else if (state == ST_ROUND) begin
                data_o      <= pack_word;
                overflow_o  <= pack_ovf;
                underflow_o <= pack_unf;
                inexact_o   <= pack_inx;
            end
        end
    end

endmodule

// File: tb/tb_iob_fp_pack.sv
// Directed bench for iob_fp_pack (DATA_W=32, EXP_W=8).
module tb_iob_fp_pack;
    logic        clk_i = 1'b0;
    logic        cke_i, arst_i, start_i, sign_i, nan_i, inf_i;
    logic [9:0]  exp_i;
    logic [26:0] mant_i;
    logic        busy_o, done_o, overflow_o, underflow_o, inexact_o;
    logic [31:0] data_o;

    int tests = 0;
    int fails = 0;

    iob_fp_pack #(.DATA_W(32), .EXP_W(8)) dut (
        .clk_i       (clk_i),
        .cke_i       (cke_i),
        .arst_i      (arst_i),
        .start_i     (start_i),
        .sign_i      (sign_i),
        .exp_i       (exp_i),
        .mant_i      (mant_i),
        .nan_i       (nan_i),
        .inf_i       (inf_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .data_o      (data_o),
        .overflow_o  (overflow_o),
        .underflow_o (underflow_o),
        .inexact_o   (inexact_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive a request ahead of the next rising edge (edge T), return #1 after it.
    task automatic launch(input logic s, input logic [9:0] e, input logic [26:0] m,
                          input logic nan, input logic inf);
        @(negedge clk_i);
        sign_i = s; exp_i = e; mant_i = m; nan_i = nan; inf_i = inf; start_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
    endtask

    // n counts rising edges from T; done_o seen after edge number n gives latency n.
    task automatic wait_done(input int n0, output int n);
        n = n0;
        while (done_o !== 1'b1 && n < 200) begin
            @(posedge clk_i); #1;
            n++;
        end
    endtask

    task automatic check_result(input string tag, input int n, input int lat,
                                input logic [31:0] xd, input logic xo,
                                input logic xu, input logic xi);
        chk({tag, " done"}, 64'(done_o), 64'(1));
        chk({tag, " latency"}, 64'(n), 64'(lat));
        chk({tag, " data"}, 64'(data_o), 64'(xd));
        chk({tag, " flags o/u/i"}, 64'({overflow_o, underflow_o, inexact_o}),
            64'({xo, xu, xi}));
        chk({tag, " busy"}, 64'(busy_o), 64'(0));
    endtask

    task automatic do_op(input string tag, input logic s, input logic [9:0] e,
                         input logic [26:0] m, input logic nan, input logic inf,
                         input logic [31:0] xd, input logic xo, input logic xu,
                         input logic xi, input int lat);
        int n;
        launch(s, e, m, nan, inf);
        wait_done(1, n);
        check_result(tag, n, lat, xd, xo, xu, xi);
    endtask

    initial begin
        int  n;
        logic seen;
        cke_i = 1'b1; arst_i = 1'b1; start_i = 1'b0; sign_i = 1'b0;
        nan_i = 1'b0; inf_i = 1'b0; exp_i = '0; mant_i = '0;
        repeat (2) @(posedge clk_i);
        #1;
        chk("reset busy", 64'(busy_o), 64'(0));
        chk("reset done", 64'(done_o), 64'(0));
        chk("reset data", 64'(data_o), 64'(0));
        chk("reset flags", 64'({overflow_o, underflow_o, inexact_o}), 64'(0));
        arst_i = 1'b0;

        // Specials (back-to-back launches also exercise start coincident with done_o).
        do_op("nan",     1'b1, 10'd5,   27'h0000123, 1'b1, 1'b1, 32'h7FC00000, 0, 0, 0, 1);
        do_op("inf neg", 1'b1, 10'd127, 27'h4000000, 1'b0, 1'b1, 32'hFF800000, 0, 0, 0, 1);
        do_op("zero neg",1'b1, 10'd127, 27'h0000000, 1'b0, 1'b0, 32'h80000000, 0, 0, 0, 1);
        // Normal paths
        do_op("one",     1'b0, 10'd127, 27'h4000000, 1'b0, 1'b0, 32'h3F800000, 0, 0, 0, 3);
        do_op("lshift23",1'b0, 10'd127, 27'h0000008, 1'b0, 1'b0, 32'h34000000, 0, 0, 0, 26);
        do_op("tie even",1'b0, 10'd127, 27'h4000004, 1'b0, 1'b0, 32'h3F800000, 0, 0, 1, 3);
        do_op("rnd carry",1'b0,10'd127, 27'h7FFFFFC, 1'b0, 1'b0, 32'h40000000, 0, 0, 1, 3);
        do_op("overflow",1'b0, 10'd254, 27'h7FFFFFC, 1'b0, 1'b0, 32'h7F800000, 1, 0, 1, 3);
        do_op("subnorm", 1'b0, 10'd0,   27'h4000000, 1'b0, 1'b0, 32'h00400000, 0, 0, 0, 4);
        do_op("sub->min",1'b0, 10'd0,   27'h7FFFFFF, 1'b0, 1'b0, 32'h00800000, 0, 0, 1, 4);
        // 10'h338 is -200
        do_op("tiny",    1'b0, 10'h338, 27'h4000000, 1'b0, 1'b0, 32'h00000000, 0, 1, 1, 4);

        // done_o is a single-cycle pulse; result held afterwards
        @(posedge clk_i); #1;
        chk("done pulse", 64'(done_o), 64'(0));
        chk("data held", 64'(data_o), 64'h0);
        chk("unf held", 64'(underflow_o), 64'(1));

        // Clock enable freezes a pending done_o
        launch(1'b1, 10'd127, 27'h4000000, 1'b0, 1'b0);
        wait_done(1, n);
        check_result("neg one", n, 3, 32'hBF800000, 0, 0, 0);
        cke_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        chk("cke done frozen", 64'(done_o), 64'(1));
        chk("cke data frozen", 64'(data_o), 64'hBF800000);
        cke_i = 1'b1;
        @(posedge clk_i); #1;
        chk("cke done release", 64'(done_o), 64'(0));

        // start_i while busy is ignored
        launch(1'b0, 10'd127, 27'h0000008, 1'b0, 1'b0);
        n = 1;
        repeat (3) begin @(posedge clk_i); #1; n++; end
        @(negedge clk_i);
        start_i = 1'b1; nan_i = 1'b1;
        @(posedge clk_i); #1;
        n++;
        start_i = 1'b0; nan_i = 1'b0;
        chk("busy mid", 64'(busy_o), 64'(1));
        chk("no early done", 64'(done_o), 64'(0));
        wait_done(n, n);
        check_result("ignored start", n, 26, 32'h34000000, 0, 0, 0);

        // Asynchronous reset mid-normalization aborts
        launch(1'b1, 10'd127, 27'h0000008, 1'b0, 1'b0);
        repeat (5) @(posedge clk_i);
        #2 arst_i = 1'b1;
        #1;
        chk("abort data", 64'(data_o), 64'(0));
        chk("abort busy", 64'(busy_o), 64'(0));
        chk("abort done", 64'(done_o), 64'(0));
        #2 arst_i = 1'b0;
        seen = 1'b0;
        repeat (30) begin
            @(posedge clk_i); #1;
            if (done_o === 1'b1) seen = 1'b1;
        end
        chk("no done after abort", 64'(seen), 64'(0));
        do_op("after abort", 1'b0, 10'd127, 27'h4000000, 1'b0, 1'b0, 32'h3F800000, 0, 0, 0, 3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
